// File: rtl/vga_timing_prog.sv
// ---------------------------------------------------------------------------
// vga_timing_prog
//   Runtime-programmable video timing generator. A timing set (resolution,
//   porches, sync widths, sync polarities) is offered on a valid/ready config
//   port, checked, and held as "pending" until the last pixel of the current
//   frame. Only then is it copied to the active set, so a frame is never torn.
//   Sync/DE/marker outputs can be delayed LEAD cycles behind the coordinate
//   outputs to line up with a downstream pixel pipeline.
//
// Ports
//   i_clk, i_rst          pixel clock, synchronous active-high reset
//   i_cfg_valid           config word offered
//   o_cfg_ready           no pending set; an offer will be taken
//   i_cfg_h / i_cfg_v     {res, fp, sync, bp}, res in the MSBs
//   i_cfg_pol             {hpol, vpol}, 1 = active-high sync
//   o_cfg_err             1-cycle pulse: offered set was rejected
//   o_cfg_applied         1-cycle pulse: pending set became active, shown with (0,0)
//   o_sx / o_sy           pixel / line counters, blanking included
//   o_hs / o_vs           sync outputs with polarity applied
//   o_de                  active-video enable
//   o_frame / o_line      markers at (0,0) and at sx=0
// ---------------------------------------------------------------------------
module vga_timing_prog #(
    parameter int unsigned W       = 12,
    parameter int unsigned LEAD    = 0,
    parameter int unsigned D_HRES  = 640,
    parameter int unsigned D_HFP   = 16,
    parameter int unsigned D_HSYNC = 96,
    parameter int unsigned D_HBP   = 48,
    parameter int unsigned D_VRES  = 480,
    parameter int unsigned D_VFP   = 10,
    parameter int unsigned D_VSYNC = 2,
    parameter int unsigned D_VBP   = 33,
    parameter bit          D_HPOL  = 1'b0,
    parameter bit          D_VPOL  = 1'b0
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_cfg_valid,
    output logic           o_cfg_ready,
    input  logic [4*W-1:0] i_cfg_h,
    input  logic [4*W-1:0] i_cfg_v,
    input  logic [1:0]     i_cfg_pol,
    output logic           o_cfg_err,
    output logic           o_cfg_applied,
    output logic [W-1:0]   o_sx,
    output logic [W-1:0]   o_sy,
    output logic           o_hs,
    output logic           o_vs,
    output logic           o_de,
    output logic           o_frame,
    output logic           o_line
);

    // One axis of timing; field order matches the packed config word.
    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] fp;
        logic [W-1:0] sync;
        logic [W-1:0] bp;
    } axis_t;

    localparam axis_t DEF_H = '{res: W'(D_HRES), fp: W'(D_HFP), sync: W'(D_HSYNC), bp: W'(D_HBP)};
    localparam axis_t DEF_V = '{res: W'(D_VRES), fp: W'(D_VFP), sync: W'(D_VSYNC), bp: W'(D_VBP)};

    // Flag bundle {hs, vs, de, frame, line}; IDLE is the inactive pattern for the defaults.
    localparam logic [4:0] IDLE = {~D_HPOL, ~D_VPOL, 3'b000};

    // Total with two guard bits so an overflowing offer is detectable.
    function automatic logic [W+1:0] axis_total(input axis_t a);
        return {2'b00, a.res} + {2'b00, a.fp} + {2'b00, a.sync} + {2'b00, a.bp};
    endfunction

    function automatic logic axis_ok(input axis_t a);
        logic [W+1:0] tot;
        tot = axis_total(a);
        return (a.res != '0) && (a.sync != '0) && (tot[W+1:W] == 2'b00);
    endfunction

    // ------------------------------------------------------------------ state
    axis_t        act_h_q, act_h_d, act_v_q, act_v_d;
    axis_t        pnd_h_q, pnd_h_d, pnd_v_q, pnd_v_d;
    logic [1:0]   act_pol_q, act_pol_d, pnd_pol_q, pnd_pol_d;
    logic         pend_q, pend_d;
    logic         run_q, run_d;      // low for the one cycle after reset that shows (0,0)
    logic [W-1:0] sx_q, sx_d, sy_q, sy_d;
    logic         err_q, err_d;
    logic         applied_q, applied_d;

    // ------------------------------------------------------- counter limits
    logic [W+1:0] htot_full, vtot_full;
    logic [W-1:0] htot, vtot;
    logic         h_last, v_last;
    logic         cfg_fire, cfg_good;

    always_comb begin
        htot_full = axis_total(act_h_q);
        vtot_full = axis_total(act_v_q);
        htot      = htot_full[W-1:0];
        vtot      = vtot_full[W-1:0];
        h_last    = (sx_q == htot - 1'b1);
        v_last    = (sy_q == vtot - 1'b1);
        cfg_fire  = i_cfg_valid && !pend_q;
        cfg_good  = axis_ok(axis_t'(i_cfg_h)) && axis_ok(axis_t'(i_cfg_v));
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        // NOTE: every _d gets a default up front, so no path through this block can infer a latch.
        act_h_d   = act_h_q;
        act_v_d   = act_v_q;
        act_pol_d = act_pol_q;
        pnd_h_d   = pnd_h_q;
        pnd_v_d   = pnd_v_q;
        pnd_pol_d = pnd_pol_q;
        pend_d    = pend_q;
        run_d     = 1'b1;
        sx_d      = sx_q;
        sy_d      = sy_q;
        err_d     = 1'b0;
        applied_d = 1'b0;

        if (run_q) begin
            if (h_last) begin
                sx_d = '0;
                if (v_last) begin
                    sy_d = '0;
                    // Frame boundary: swap in the pending set together with the wrap to (0,0).
                    if (pend_q) begin
                        act_h_d   = pnd_h_q;
                        act_v_d   = pnd_v_q;
                        act_pol_d = pnd_pol_q;
                        pend_d    = 1'b0;
                        applied_d = 1'b1;
                    end
                end else begin
                    sy_d = sy_q + 1'b1;
                end
            end else begin
                sx_d = sx_q + 1'b1;
            end
        end

        // Evaluated after the apply so a same-cycle accept leaves the new word pending.
        if (cfg_fire) begin
            if (cfg_good) begin
                pnd_h_d   = axis_t'(i_cfg_h);
                pnd_v_d   = axis_t'(i_cfg_v);
                pnd_pol_d = i_cfg_pol;
                pend_d    = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (i_rst) begin
            act_h_q   <= DEF_H;
            act_v_q   <= DEF_V;
            act_pol_q <= {D_HPOL, D_VPOL};
            pnd_h_q   <= DEF_H;
            pnd_v_q   <= DEF_V;
            pnd_pol_q <= {D_HPOL, D_VPOL};
            pend_q    <= 1'b0;
            run_q     <= 1'b0;
            sx_q      <= '0;
            sy_q      <= '0;
            err_q     <= 1'b0;
            applied_q <= 1'b0;
        end else begin
            act_h_q   <= act_h_d;
            act_v_q   <= act_v_d;
            act_pol_q <= act_pol_d;
            pnd_h_q   <= pnd_h_d;
            pnd_v_q   <= pnd_v_d;
            pnd_pol_q <= pnd_pol_d;
            pend_q    <= pend_d;
            run_q     <= run_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            err_q     <= err_d;
            applied_q <= applied_d;
        end
    end

    // -------------------------------------------------- flags from counters
    logic [W-1:0] h_sync_beg, h_sync_end, v_sync_beg, v_sync_end;
    logic         hs_in, vs_in;
    logic [4:0]   flags_c;

    always_comb begin
        h_sync_beg = act_h_q.res + act_h_q.fp;
        h_sync_end = h_sync_beg + act_h_q.sync;
        v_sync_beg = act_v_q.res + act_v_q.fp;
        v_sync_end = v_sync_beg + act_v_q.sync;
        hs_in      = run_q && (sx_q >= h_sync_beg) && (sx_q < h_sync_end);
        vs_in      = run_q && (sy_q >= v_sync_beg) && (sy_q < v_sync_end);
        flags_c    = {~(hs_in ^ act_pol_q[1]),
                      ~(vs_in ^ act_pol_q[0]),
                      run_q && (sx_q < act_h_q.res) && (sy_q < act_v_q.res),
                      run_q && (sx_q == '0) && (sy_q == '0),
                      run_q && (sx_q == '0)};
    end

    // ------------------------------------------------------ LEAD delay line
    logic [4:0] flags_o;

    generate
        if (LEAD == 0) begin : g_no_delay
            assign flags_o = flags_c;
        end else begin : g_delay
            logic [4:0] dly_q [LEAD];
            always_ff @(posedge i_clk) begin
                // NOTE: this small delay line is reset on purpose so it never emits stale sync/DE after reset.
                if (i_rst) begin
                    for (int i = 0; i < LEAD; i++) dly_q[i] <= IDLE;
                end else begin
                    dly_q[0] <= flags_c;
                    for (int i = 1; i < LEAD; i++) dly_q[i] <= dly_q[i-1];
                end
            end
            assign flags_o = dly_q[LEAD-1];
        end
    endgenerate

    // ---------------------------------------------------------------- outputs
    assign o_sx          = sx_q;
    assign o_sy          = sy_q;
    assign {o_hs, o_vs, o_de, o_frame, o_line} = flags_o;
    assign o_cfg_ready   = ~pend_q;
    assign o_cfg_err     = err_q;
    assign o_cfg_applied = applied_q;

endmodule

// File: tb/tb_vga_timing_prog.sv
module tb_vga_timing_prog;

    localparam int W = 12;
    // Scaled-down defaults keep a frame at 25x17 = 425 cycles.
    localparam int DHR = 16, DHF = 2, DHS = 3, DHB = 4;
    localparam int DVR = 10, DVF = 2, DVS = 2, DVB = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_valid;
    logic [4*W-1:0] cfg_h, cfg_v;
    logic [1:0]     cfg_pol;

    logic           a_ready, a_err, a_applied, a_hs, a_vs, a_de, a_frame, a_line;
    logic [W-1:0]   a_sx, a_sy;
    logic           b_ready, b_err, b_applied, b_hs, b_vs, b_de, b_frame, b_line;
    logic [W-1:0]   b_sx, b_sy;

    always #5 clk = ~clk;

    vga_timing_prog #(.W(W), .LEAD(0),
        .D_HRES(DHR), .D_HFP(DHF), .D_HSYNC(DHS), .D_HBP(DHB),
        .D_VRES(DVR), .D_VFP(DVF), .D_VSYNC(DVS), .D_VBP(DVB),
        .D_HPOL(1'b0), .D_VPOL(1'b0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_cfg_valid(cfg_valid), .o_cfg_ready(a_ready),
        .i_cfg_h(cfg_h), .i_cfg_v(cfg_v), .i_cfg_pol(cfg_pol),
        .o_cfg_err(a_err), .o_cfg_applied(a_applied), .o_sx(a_sx), .o_sy(a_sy),
        .o_hs(a_hs), .o_vs(a_vs), .o_de(a_de), .o_frame(a_frame), .o_line(a_line));

    vga_timing_prog #(.W(W), .LEAD(3),
        .D_HRES(DHR), .D_HFP(DHF), .D_HSYNC(DHS), .D_HBP(DHB),
        .D_VRES(DVR), .D_VFP(DVF), .D_VSYNC(DVS), .D_VBP(DVB),
        .D_HPOL(1'b0), .D_VPOL(1'b0)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_cfg_valid(cfg_valid), .o_cfg_ready(b_ready),
        .i_cfg_h(cfg_h), .i_cfg_v(cfg_v), .i_cfg_pol(cfg_pol),
        .o_cfg_err(b_err), .o_cfg_applied(b_applied), .o_sx(b_sx), .o_sy(b_sy),
        .o_hs(b_hs), .o_vs(b_vs), .o_de(b_de), .o_frame(b_frame), .o_line(b_line));

    typedef struct packed {
        logic hs, vs, de, frame, line;
    } flags_t;

    typedef struct packed {
        logic [W-1:0] sx, sy;
        flags_t       f;      // LEAD=0 view
        flags_t       fl;     // LEAD=3 view
        logic         ready, err, applied;
    } exp_t;

    exp_t   sb_q[$];
    flags_t lead_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------- reference model
    int mh[4], mv[4], ph[4], pv[4];
    bit mhp, mvp, php, pvp;
    bit m_pend, m_run, m_err, m_app;
    int m_sx, m_sy;

    function automatic int fld(input logic [4*W-1:0] c, input int idx);
        logic [W-1:0] v;
        v = c[(4-idx)*W-1 -: W];
        return int'(v);
    endfunction

    function automatic bit axis_ok(input logic [4*W-1:0] c);
        return fld(c, 0) != 0 && fld(c, 2) != 0 &&
               (fld(c, 0) + fld(c, 1) + fld(c, 2) + fld(c, 3)) < (1 << W);
    endfunction

    function automatic logic [4*W-1:0] mk(input int r, input int f, input int s, input int b);
        return {W'(r), W'(f), W'(s), W'(b)};
    endfunction

    task automatic model_step();
        bit fire, good;
        int htot, vtot;
        flags_t f;
        exp_t e;
        if (rst) begin
            mh = '{DHR, DHF, DHS, DHB};
            mv = '{DVR, DVF, DVS, DVB};
            mhp = 0; mvp = 0;
            m_pend = 0; m_run = 0; m_err = 0; m_app = 0;
            m_sx = 0; m_sy = 0;
        end else begin
            fire  = cfg_valid && !m_pend;
            good  = axis_ok(cfg_h) && axis_ok(cfg_v);
            m_err = fire && !good;
            m_app = 0;
            htot  = mh[0] + mh[1] + mh[2] + mh[3];
            vtot  = mv[0] + mv[1] + mv[2] + mv[3];
            if (!m_run) m_run = 1;
            else if (m_sx == htot - 1) begin
                m_sx = 0;
                if (m_sy == vtot - 1) begin
                    m_sy = 0;
                    if (m_pend) begin
                        mh = ph; mv = pv; mhp = php; mvp = pvp;
                        m_pend = 0; m_app = 1;
                    end
                end else m_sy++;
            end else m_sx++;
            if (fire && good) begin
                for (int i = 0; i < 4; i++) begin
                    ph[i] = fld(cfg_h, i);
                    pv[i] = fld(cfg_v, i);
                end
                php = cfg_pol[1]; pvp = cfg_pol[0];
                m_pend = 1;
            end
        end
        f.de    = m_run && m_sx < mh[0] && m_sy < mv[0];
        f.frame = m_run && m_sx == 0 && m_sy == 0;
        f.line  = m_run && m_sx == 0;
        f.hs    = (m_run && m_sx >= mh[0] + mh[1] && m_sx < mh[0] + mh[1] + mh[2]) ? mhp : !mhp;
        f.vs    = (m_run && m_sy >= mv[0] + mv[1] && m_sy < mv[0] + mv[1] + mv[2]) ? mvp : !mvp;
        if (rst) begin
            lead_q.delete();
            repeat (3) lead_q.push_back('{hs: 1'b1, vs: 1'b1, de: 1'b0, frame: 1'b0, line: 1'b0});
        end
        lead_q.push_back(f);
        e.sx = W'(m_sx); e.sy = W'(m_sy);
        e.f  = f;
        e.fl = lead_q.pop_front();
        e.ready = !m_pend; e.err = m_err; e.applied = m_app;
        sb_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Scoreboard: compare each expected entry on the falling edge after it was pushed.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sx", a_sx, e.sx);
            check("sy", a_sy, e.sy);
            check("hs", a_hs, e.f.hs);
            check("vs", a_vs, e.f.vs);
            check("de", a_de, e.f.de);
            check("frame", a_frame, e.f.frame);
            check("line", a_line, e.f.line);
            check("ready", a_ready, e.ready);
            check("err", a_err, e.err);
            check("applied", a_applied, e.applied);
            check("l3_sx", b_sx, e.sx);
            check("l3_sy", b_sy, e.sy);
            check("l3_hs", b_hs, e.fl.hs);
            check("l3_vs", b_vs, e.fl.vs);
            check("l3_de", b_de, e.fl.de);
            check("l3_frame", b_frame, e.fl.frame);
            check("l3_line", b_line, e.fl.line);
            check("l3_applied", b_applied, e.applied);
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic offer(input logic [4*W-1:0] h, input logic [4*W-1:0] v, input logic [1:0] p);
        cfg_h = h; cfg_v = v; cfg_pol = p; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_pos(input int x, input int y);
        int n = 0;
        while (!(m_sx == x && m_sy == y) && n < 2000) begin step(); n++; end
        if (n >= 2000) check("wait_pos_timeout", 0, 1);
    endtask

    task automatic wait_applied();
        int n = 0;
        while (a_applied !== 1'b1 && n < 2000) begin step(); n++; end
        check("applied_seen", a_applied, 1);
        check("applied_sx0", a_sx, 0);
        check("applied_sy0", a_sy, 0);
    endtask

    task automatic measure(input string tag, input int exp_per, input int exp_de);
        int n = 0, per = 0, des = 0;
        while (a_frame !== 1'b1 && n < 2000) begin step(); n++; end
        if (n >= 2000) check({tag, "_frame_timeout"}, 0, 1);
        do begin
            des += int'(a_de);
            per++;
            step();
        end while (a_frame !== 1'b1 && per < 2000);
        check({tag, "_period"}, per, exp_per);
        check({tag, "_de_count"}, des, exp_de);
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_h = '0; cfg_v = '0; cfg_pol = 2'b00;
        repeat (3) step();
        check("rst_frame", a_frame, 0);
        check("rst_hs", a_hs, 1);
        rst = 1'b0;
        step();
        check("first_frame", a_frame, 1);
        check("first_line", a_line, 1);

        // Defaults: 25x17 frame, 16x10 active.
        measure("def", 425, 160);

        // Mid-frame reprogram; current frame continues unchanged.
        wait_pos(5, 5);
        offer(mk(20, 2, 4, 6), mk(8, 1, 2, 3), 2'b11);
        check("ready_drop", a_ready, 0);
        // Second offer while pending: ignored, no error.
        cfg_valid = 1'b1; cfg_h = mk(12, 1, 1, 1); cfg_v = mk(6, 1, 1, 1);
        repeat (3) step();
        cfg_valid = 1'b0;
        check("no_err_pending", a_err, 0);
        wait_applied();
        check("new_hs_inactive_low", a_hs, 0);
        measure("cfg1", 32 * 14, 20 * 8);
        check("ready_after_apply", a_ready, 1);

        // Rejected offers: zero fields and overflow on either axis.
        offer(mk(20, 2, 0, 6), mk(8, 1, 2, 3), 2'b00);
        check("err_hsync0", a_err, 1);
        step();
        check("err_pulse_end", a_err, 0);
        offer(mk(4000, 50, 40, 10), mk(8, 1, 2, 3), 2'b00);
        check("err_hovf", a_err, 1);
        offer(mk(20, 2, 4, 6), mk(0, 1, 2, 3), 2'b00);
        check("err_vres0", a_err, 1);
        offer(mk(20, 2, 4, 6), mk(8, 1, 2, 4090), 2'b00);
        check("err_vovf", a_err, 1);
        measure("cfg1_kept", 32 * 14, 20 * 8);

        // Reset mid-frame with a pending set.
        offer(mk(10, 1, 2, 3), mk(6, 1, 1, 2), 2'b10);
        check("pend_before_rst", a_ready, 0);
        wait_pos(10, 5);
        rst = 1'b1;
        step();
        check("midrst_sx", a_sx, 0);
        check("midrst_de", a_de, 0);
        rst = 1'b0;
        step();
        check("midrst_ready", a_ready, 1);
        measure("def_after_rst", 425, 160);

        // Minimal mode.
        offer(mk(1, 1, 1, 1), mk(1, 1, 1, 1), 2'b01);
        check("min_no_err", a_err, 0);
        wait_applied();
        measure("min", 16, 1);
        repeat (40) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
